// File: rtl/acs_sweep_sequencer.sv
// Sweeps the 4-wide ACS unit across all 2^WD_FSM segments for each accepted branch-metric symbol.
// Optional survivor stall input is compiled in only when ACS_SEQ_STALL_EN is defined.
module acs_sweep_sequencer #(
    parameter int  WD_FSM   = 6,
    parameter int  WD_STATE = 8,
    parameter int  WD_SCNT  = 16,
    localparam int SEGW     = (WD_FSM > 0) ? WD_FSM : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               SymbolValid,
    input  logic               SymbolFirst,
    output logic               SymbolReady,
    output logic               Active,
    output logic [SEGW-1:0]    ACSSegment,
    output logic               Init,
    output logic               Hold,
    output logic               CompareStart,
    output logic               SymbolDone,
    output logic [WD_SCNT-1:0] SymbolCount
`ifdef ACS_SEQ_STALL_EN
    ,
    input  logic               SurvStall
`endif
);
    localparam logic [0:0]      IDLE     = 1'b0;
    localparam logic [0:0]      SWEEP    = 1'b1;
    localparam int              SUW      = (WD_STATE > 0) ? $clog2(WD_STATE + 1) : 1;
    localparam logic [SEGW-1:0] SEG_LAST = SEGW'((1 << WD_FSM) - 1);
    localparam logic [SUW-1:0]  SU_MAX   = SUW'(WD_STATE);
    localparam logic            SINGLE   = (WD_FSM == 0);

    logic [0:0]         state;
    logic [SEGW-1:0]    seg;
    logic               active_r;
    logic               init_r;
    logic               hold_r;
    logic               cmp_r;
    logic [WD_SCNT-1:0] sym_cnt;
    logic [SUW-1:0]     startup_cnt;

    logic               stall;
    logic               seg_last;
    logic               hold_fire;
    logic               accept;
    logic [SUW-1:0]     startup_inc;
    logic [SUW-1:0]     startup_base;
    logic [SUW-1:0]     startup_eff;

`ifdef ACS_SEQ_STALL_EN
    assign stall = SurvStall & (state == SWEEP);
`else
    assign stall = 1'b0;
`endif

    assign seg_last    = (seg == SEG_LAST);
    assign hold_fire   = (state == SWEEP) & seg_last & ~stall;
    assign SymbolReady = ~Reset & ((state == IDLE) | hold_fire);
    assign accept      = SymbolValid & SymbolReady;

    assign startup_inc  = (startup_cnt >= SU_MAX) ? SU_MAX : startup_cnt + SUW'(1);
    // A symbol closing on the same edge as a new acceptance already counts toward its startup.
    assign startup_base = hold_fire ? startup_inc : startup_cnt;
    assign startup_eff  = SymbolFirst ? '0 : startup_base;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            seg         <= '0;
            active_r    <= 1'b0;
            init_r      <= 1'b0;
            hold_r      <= 1'b0;
            cmp_r       <= 1'b0;
            sym_cnt     <= '0;
            startup_cnt <= '0;
        end else if (!stall) begin
            if (hold_fire) begin
                sym_cnt <= sym_cnt + WD_SCNT'(1);
            end
            if (accept) begin
                state       <= SWEEP;
                seg         <= '0;
                active_r    <= 1'b1;
                init_r      <= 1'b1;
                hold_r      <= SINGLE;
                cmp_r       <= (startup_eff >= SU_MAX);
                startup_cnt <= startup_eff;
            end else if (hold_fire) begin
                state       <= IDLE;
                seg         <= '0;
                active_r    <= 1'b0;
                init_r      <= 1'b0;
                hold_r      <= 1'b0;
                cmp_r       <= 1'b0;
                startup_cnt <= startup_inc;
            end else if (state == SWEEP) begin
                seg    <= seg + SEGW'(1);
                init_r <= 1'b0;
                hold_r <= ((seg + SEGW'(1)) == SEG_LAST);
            end
        end
    end

    assign Active       = active_r & ~stall;
    assign ACSSegment   = seg;
    assign Init         = init_r;
    assign Hold         = hold_r & ~stall;
    assign SymbolDone   = hold_r & ~stall;
    assign CompareStart = cmp_r;
    assign SymbolCount  = sym_cnt;

endmodule

// File: tb/tb_acs_sweep_sequencer.sv
// Bench for acs_sweep_sequencer: directed scenarios plus random traffic against a symbol-level model.
module tb_acs_sweep_sequencer;
    localparam int NSEG = 64;
    localparam int WST  = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        SymbolValid = 1'b0;
    logic        SymbolFirst = 1'b0;
    logic        SymbolReady;
    logic        Active;
    logic [5:0]  ACSSegment;
    logic        Init;
    logic        Hold;
    logic        CompareStart;
    logic        SymbolDone;
    logic [15:0] SymbolCount;
`ifdef ACS_SEQ_STALL_EN
    logic        SurvStall = 1'b0;
`endif

    acs_sweep_sequencer #(.WD_FSM(6), .WD_STATE(WST), .WD_SCNT(16)) dut (
        .Clock(Clock), .Reset(Reset), .SymbolValid(SymbolValid), .SymbolFirst(SymbolFirst),
        .SymbolReady(SymbolReady), .Active(Active), .ACSSegment(ACSSegment), .Init(Init),
        .Hold(Hold), .CompareStart(CompareStart), .SymbolDone(SymbolDone),
        .SymbolCount(SymbolCount)
`ifdef ACS_SEQ_STALL_EN
        , .SurvStall(SurvStall)
`endif
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Model: segment within the current sweep (-1 when idle), symbols done, symbols done since SymbolFirst.
    int m_seg = -1;
    bit m_cmp = 0;
    int m_count = 0;
    int m_since = 0;
    bit m_rst = 1, m_v = 0, m_f = 0, m_stall = 0;

    function automatic logic [27:0] got();
        return {SymbolReady, Active, Init, Hold, SymbolDone, CompareStart, ACSSegment, SymbolCount};
    endfunction

    function automatic logic [27:0] expv();
        bit         stl  = m_stall && (m_seg >= 0);
        bit         last = (m_seg == NSEG - 1);
        bit         rdy  = !m_rst && ((m_seg < 0) || (last && !stl));
        logic [5:0] sg   = (m_seg < 0) ? 6'd0 : 6'(m_seg);
        return {rdy, (m_seg >= 0) && !stl, m_seg == 0, last && !stl, last && !stl, m_cmp, sg,
                16'(m_count % 65536)};
    endfunction

    task automatic drive(input bit v, input bit f, input bit r, input bit s);
        SymbolValid = v; SymbolFirst = f; Reset = r;
        m_v = v; m_f = f; m_rst = r; m_stall = s;
`ifdef ACS_SEQ_STALL_EN
        SurvStall = s;
`endif
        #1;
    endtask

    task automatic tick(output bit acc, output bit done);
        bit stl  = m_stall && (m_seg >= 0);
        bit last = (m_seg == NSEG - 1);
        bit rdy  = !m_rst && ((m_seg < 0) || (last && !stl));
        acc  = m_v && rdy;
        done = 0;
        @(posedge Clock);
        if (m_rst) begin
            m_seg = -1; m_cmp = 0; m_count = 0; m_since = 0;
        end else if (!stl) begin
            done = last;
            if (done) begin m_count++; m_since++; end
            if (acc) begin
                if (m_f) m_since = 0;
                m_cmp = (m_since >= WST);
                m_seg = 0;
            end else if (done) begin
                m_seg = -1; m_cmp = 0;
            end else if (m_seg >= 0) begin
                m_seg++;
            end
        end
        @(negedge Clock);
    endtask

    task automatic test_reset();
        bit acc, done;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, c < 2, 0);
            total++;
            if (got() !== expv()) begin
                bad++; $display("FAIL reset c=%0d got=%h exp=%h", c, got(), expv());
            end
            tick(acc, done);
        end
        total++;
        if (got() !== 28'h8000000) begin
            bad++; $display("FAIL reset_idle got=%h exp=%h", got(), 28'h8000000);
        end
    endtask

    task automatic test_single();
        bit acc, done, any_cmp = 0;
        int hold_at = -1;
        drive(1, 1, 0, 0);
        total++;
        if (got() !== expv()) begin bad++; $display("FAIL single_acc got=%h exp=%h", got(), expv()); end
        tick(acc, done);
        for (int k = 1; k <= 70; k++) begin
            drive(0, 0, 0, 0);
            total++;
            if (got() !== expv()) begin bad++; $display("FAIL single k=%0d got=%h exp=%h", k, got(), expv()); end
            if (k == 1) begin
                total++;
                if (Init !== 1'b1 || ACSSegment !== 6'd0) begin
                    bad++; $display("FAIL single_first init=%b seg=%0d exp 1/0", Init, ACSSegment);
                end
            end
            if (k == 65) begin
                total++;
                if (Active !== 1'b0) begin bad++; $display("FAIL single_end active=%b exp 0", Active); end
            end
            if (Hold === 1'b1 && SymbolDone === 1'b1 && ACSSegment === 6'd63 && hold_at < 0) hold_at = k;
            if (CompareStart !== 1'b0) any_cmp = 1;
            tick(acc, done);
        end
        total++;
        if (hold_at != 64) begin bad++; $display("FAIL single_hold_latency got=%0d exp=64", hold_at); end
        total++;
        if (SymbolCount !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", SymbolCount); end
        total++;
        if (any_cmp) begin bad++; $display("FAIL single_cmp got=1 exp=0"); end
    endtask

    task automatic test_stream(input string name, input int nsym, input int restart_at);
        bit   acc, done, prev = 0, v, f;
        int   acc_n = 0, act = 0, falls = 0, since;
        logic cs_seen[$];
        for (int c = 0; c < 2; c++) begin drive(0, 0, 1, 0); tick(acc, done); end
        for (int c = 0; c < nsym * NSEG + 20; c++) begin
            v = (acc_n < nsym);
            f = (acc_n == 0) || (acc_n + 1 == restart_at);
            drive(v, f, 0, 0);
            total++;
            if (got() !== expv()) begin bad++; $display("FAIL %s c=%0d got=%h exp=%h", name, c, got(), expv()); end
            if (Active && Init) cs_seen.push_back(CompareStart);
            if (Active) act++;
            if (prev && !Active) falls++;
            prev = Active;
            tick(acc, done);
            if (acc) acc_n++;
        end
        total++;
        if (cs_seen.size() != nsym) begin bad++; $display("FAIL %s_nsym got=%0d exp=%0d", name, cs_seen.size(), nsym); end
        for (int k = 1; k <= cs_seen.size(); k++) begin
            since = (restart_at > 0 && k >= restart_at) ? k - restart_at : k - 1;
            total++;
            if (cs_seen[k-1] !== (since >= WST)) begin
                bad++; $display("FAIL %s_cmp sym=%0d got=%b exp=%b", name, k, cs_seen[k-1], since >= WST);
            end
        end
        total++;
        if (act != nsym * NSEG || falls != 1) begin
            bad++; $display("FAIL %s_gapless active=%0d falls=%0d exp %0d/1", name, act, falls, nsym * NSEG);
        end
        total++;
        if (SymbolCount !== 16'(nsym)) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, SymbolCount, nsym); end
    endtask

    task automatic test_mid_reset();
        bit acc, done, saw_hold = 0;
        int c;
        for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0); tick(acc, done); end
        drive(1, 0, 0, 0);
        tick(acc, done);
        c = 0;
        while (ACSSegment !== 6'd30 && c < 100) begin
            drive(0, 0, 0, 0);
            total++;
            if (got() !== expv()) begin bad++; $display("FAIL midrst c=%0d got=%h exp=%h", c, got(), expv()); end
            if (Hold || SymbolDone) saw_hold = 1;
            tick(acc, done);
            c++;
        end
        total++;
        if (c >= 100) begin bad++; $display("FAIL midrst_timeout seg=%0d exp=30", ACSSegment); end
        drive(0, 0, 1, 0);
        total++;
        if (got() !== expv()) begin bad++; $display("FAIL midrst_assert got=%h exp=%h", got(), expv()); end
        if (Hold || SymbolDone) saw_hold = 1;
        tick(acc, done);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            total++;
            if (Active !== 1'b0 || ACSSegment !== 6'd0 || SymbolReady !== 1'b1 || SymbolCount !== 16'd0) begin
                bad++; $display("FAIL midrst_idle act=%b seg=%0d rdy=%b cnt=%0d exp 0/0/1/0",
                                Active, ACSSegment, SymbolReady, SymbolCount);
            end
            if (Hold || SymbolDone) saw_hold = 1;
            tick(acc, done);
        end
        total++;
        if (saw_hold) begin bad++; $display("FAIL midrst_hold got=1 exp=0"); end
    endtask

`ifdef ACS_SEQ_STALL_EN
    task automatic test_stall();
        bit acc, done;
        int c = 0;
        for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0); tick(acc, done); end
        drive(1, 1, 0, 0);
        tick(acc, done);
        while (!(ACSSegment === 6'd63 && Active === 1'b1) && c < 100) begin
            drive(0, 0, 0, 0);
            tick(acc, done);
            c++;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1);
            total++;
            if (got() !== expv()) begin bad++; $display("FAIL stall i=%0d got=%h exp=%h", i, got(), expv()); end
            total++;
            if (Hold !== 1'b0 || SymbolReady !== 1'b0 || Active !== 1'b0 || ACSSegment !== 6'd63) begin
                bad++; $display("FAIL stall_freeze hold=%b rdy=%b act=%b seg=%0d exp 0/0/0/63",
                                Hold, SymbolReady, Active, ACSSegment);
            end
            tick(acc, done);
        end
        drive(0, 0, 0, 0);
        total++;
        if (Hold !== 1'b1 || SymbolDone !== 1'b1 || SymbolReady !== 1'b1 || SymbolCount !== 16'd0) begin
            bad++; $display("FAIL stall_resume hold=%b done=%b rdy=%b cnt=%0d exp 1/1/1/0",
                            Hold, SymbolDone, SymbolReady, SymbolCount);
        end
        tick(acc, done);
        total++;
        if (SymbolCount !== 16'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", SymbolCount); end
    endtask
`endif

    task automatic test_random();
        bit acc, done, v, f, r, s;
        for (int c = 0; c < 4000; c++) begin
            v = ($urandom % 3) != 0;
            f = ($urandom % 16) == 0;
            r = ($urandom % 700) == 0;
`ifdef ACS_SEQ_STALL_EN
            s = ($urandom % 5) == 0;
`else
            s = 0;
`endif
            drive(v, f, r, s);
            total++;
            if (got() !== expv()) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, got(), expv()); end
            tick(acc, done);
        end
    endtask

    initial begin
        @(negedge Clock);
        test_reset();
        test_single();
        test_stream("back_to_back", 10, 0);
        test_stream("first_restart", 22, 12);
        test_mid_reset();
`ifdef ACS_SEQ_STALL_EN
        test_stall();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
